bcd_down_counter: RTL
=====================

Name: bcd_down_counter

Overview:
- Multi-digit BCD down counter that counts from a loaded preset to 00, then flags terminal count.
- Mirror of the team's 0-to-9 up counter: it decrements instead of increments, and emits a borrow instead of a carry.
- Used as a countdown timer feeding the board's 7-segment displays. Counting is paced by an external tick, normally a prescaler strobe.
- One-digit slices chain borrow-to-borrow, the same way the up counters chain carry-to-carry.

Parameters:
- DIGITS, 2, number of BCD digits (1..4).
- WRAP, 0, 0 = stop at 00 and enter DONE; 1 = reload the stored preset on the tick after 00 and keep running.

Ports:
- clk  input  1  system clock, rising edge.
- clear_n  input  1  asynchronous reset, active-low.
- load  input  1  capture preset into the count and the stored preset register.
- preset  input  4*DIGITS  BCD preset; digit 0 is in [3:0].
- start  input  1  begin counting from IDLE or DONE.
- hold  input  1  freeze the count while high; state is kept.
- tick  input  1  single-cycle count enable strobe.
- count  output  4*DIGITS  current BCD value.
- borrow_out  output  1  one-cycle pulse when a decrement is applied at 00.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse on entry to DONE.
- err  output  1  sticky flag: a non-BCD preset digit was loaded.

Behaviour:
- Reset (clear_n low, asynchronous): count = 0, stored preset = 0, state = IDLE, borrow_out = 0, busy = 0, done = 0, err = 0. All outputs are registered.
- States: IDLE, RUN, DONE.
- IDLE: start -> RUN on the next edge. tick has no effect.
- RUN: on each edge with tick = 1 and hold = 0, the count decrements by one. Digit 0 borrows; digit k borrows only when all lower digits are 0.
  - Per-digit rule: a nonzero digit decrements by 1; a 0 digit with borrow_in goes to 9 and asserts its borrow.
  - Decrement applied at 00 (every digit 0), WRAP = 0: count stays 0, state -> DONE, done and borrow_out pulse for one cycle. Count never shows 99.
  - Decrement applied at 00, WRAP = 1: count <= stored preset, borrow_out pulses, state stays RUN, done stays 0.
- DONE: count holds 0. start -> RUN with the count unchanged. The next tick then fires borrow_out/done again, or reloads if WRAP = 1.
- load, any state, highest priority:
  - Same edge: count <= preset and stored preset <= preset; state -> IDLE.
  - Pulses are suppressed that cycle.
  - A start on the same cycle is ignored.
- Preset digit > 9: that digit is loaded as 9 and err is set. err clears only on reset.
- hold high: no decrement and no pulses. Ticks arriving during hold are dropped, not queued.
- Latency: the count changes on the edge where tick is sampled. Pulses are asserted in the cycle after that edge.
- Preset of 00 followed by start: the first tick produces borrow_out/done.
- A tick asserted on consecutive cycles is honoured every cycle; no edge detection is done on tick.

Decomposition:
- Shared package/include:
  - state encodings: IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2.
  - BCD_MAX = 4'd9.
  - the digit width constant (4).
- Sub-module bcd_down_digit: one digit.
  - Ports: clk, clear_n, load, din[3:0], dec_in, q[3:0], borrow.
  - Implements the per-digit rule above plus clamp-to-9 on load.
  - The top level instantiates it DIGITS times in a generate loop, chaining the enables.

Test Plan:
- Reset mid-count: DIGITS = 2, count at 47 in RUN, drop clear_n with no clock edge -> count = 00 and state IDLE immediately; all pulses 0.
- Cross-digit borrow: load 10, start, one tick -> count 09; tick -> 08; no borrow_out.
- Terminal count, WRAP = 0: load 02, start, three ticks -> counts 01, 00, then borrow_out and done each pulse exactly one cycle; count stays 00; busy = 0.
- Wrap, WRAP = 1: load 03, start, four ticks -> 02, 01, 00, 03; borrow_out pulses once on the fourth tick; done never asserts.
- hold and load priority: in RUN at 25, hold high for 5 ticks -> count stays 25. Then load 37 together with start and tick -> count 37, state IDLE.
- Invalid BCD: load preset 8'hA4 -> count 94 and err = 1. err persists through further loads and clears only on clear_n low.

Source files
------------

// File: rtl/bcd_down_counter_pkg.sv
// Shared definitions for the BCD down counter and its digit slice.
//   state_t   : controller states (IDLE, RUN, DONE)
//   BCD_MAX   : largest legal BCD digit
//   DIGIT_W   : bits per BCD digit
//   is_bcd()  : true when a nibble is a legal BCD digit
//   clamp_bcd(): maps an illegal nibble onto BCD_MAX
package bcd_down_counter_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [3:0] BCD_MAX = 4'd9;
   localparam int         DIGIT_W = 4;

   function automatic logic is_bcd(input logic [3:0] d);
      return (d <= BCD_MAX);
   endfunction

   function automatic logic [3:0] clamp_bcd(input logic [3:0] d);
      return is_bcd(d) ? d : BCD_MAX;
   endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD digit of the down counter.
//   clk     : system clock, rising edge
//   clear_n : asynchronous reset, active-low (digit -> 0)
//   load    : capture din (illegal values clamp to 9); wins over dec_in
//   din     : digit value to load
//   dec_in  : decrement request (borrow from the next lower digit)
//   q       : registered digit value
//   borrow  : combinational; high when a decrement hits this digit at 0,
//             which is the decrement request for the next higher digit
module bcd_down_digit
   import bcd_down_counter_pkg::*;
(
   input  logic       clk,
   input  logic       clear_n,
   input  logic       load,
   input  logic [3:0] din,
   input  logic       dec_in,
   output logic [3:0] q,
   output logic       borrow
);

   logic [3:0] q_reg;

   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         q_reg <= '0;
      end else if (load) begin
         q_reg <= clamp_bcd(din);
      end else if (dec_in) begin
         q_reg <= (q_reg == 4'd0) ? BCD_MAX : (q_reg - 4'd1);
      end
   end

   assign q      = q_reg;
   assign borrow = dec_in && (q_reg == 4'd0);

endmodule

// File: rtl/bcd_down_counter.sv
// Multi-digit BCD countdown counter paced by an external tick.
//   clk        : system clock, rising edge
//   clear_n    : asynchronous reset, active-low
//   load       : capture preset into count and stored preset; enter IDLE
//   preset     : BCD preset, digit 0 in [3:0]
//   start      : IDLE/DONE -> RUN
//   hold       : freeze the count (ticks during hold are dropped)
//   tick       : count enable strobe, honoured every cycle it is high
//   count      : current BCD value
//   borrow_out : one-cycle pulse when a decrement is applied at all-zero
//   busy       : high in RUN
//   done       : one-cycle pulse on entry to DONE
//   err        : sticky, set when a preset with a non-BCD digit is loaded
module bcd_down_counter
   import bcd_down_counter_pkg::*;
#(
   parameter int DIGITS = 2,
   parameter int WRAP   = 0
) (
   input  logic                        clk,
   input  logic                        clear_n,
   input  logic                        load,
   input  logic [DIGIT_W*DIGITS-1:0]   preset,
   input  logic                        start,
   input  logic                        hold,
   input  logic                        tick,
   output logic [DIGIT_W*DIGITS-1:0]   count,
   output logic                        borrow_out,
   output logic                        busy,
   output logic                        done,
   output logic                        err
);

   localparam int W = DIGIT_W * DIGITS;

   state_t         state_reg;
   logic [W-1:0]   stored_reg;
   logic           borrow_reg;
   logic           done_reg;
   logic           busy_reg;
   logic           err_reg;

   logic [DIGITS:0]   dec_chain;
   logic [DIGITS-1:0] bad_digit;
   logic              dec_apply;
   logic              terminal;
   logic              digit_load;
   logic [W-1:0]      digit_din;

   // A decrement is only applied in RUN, on a tick, without hold, and
   // never on a load cycle (load has priority over everything).
   assign dec_apply    = (state_reg == RUN) && tick && !hold && !load;
   assign dec_chain[0] = dec_apply;

   // The borrow rippling out of the top digit means the decrement landed
   // on all-zero. Instead of letting the digits roll to 99, the digits are
   // reloaded that same edge: with zero (stop) or with the stored preset
   // (wrap). The digit's load path overrides its decrement path.
   assign terminal   = dec_chain[DIGITS];
   assign digit_load = load || terminal;
   assign digit_din  = load ? preset : ((WRAP != 0) ? stored_reg : '0);

   generate
      for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
         bcd_down_digit u_digit (
            .clk     (clk),
            .clear_n (clear_n),
            .load    (digit_load),
            .din     (digit_din[gi*DIGIT_W +: DIGIT_W]),
            .dec_in  (dec_chain[gi]),
            .q       (count[gi*DIGIT_W +: DIGIT_W]),
            .borrow  (dec_chain[gi+1])
         );
         assign bad_digit[gi] = !is_bcd(preset[gi*DIGIT_W +: DIGIT_W]);
      end
   endgenerate

   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         state_reg  <= IDLE;
         stored_reg <= '0;
         borrow_reg <= 1'b0;
         done_reg   <= 1'b0;
         busy_reg   <= 1'b0;
         err_reg    <= 1'b0;
      end else begin
         borrow_reg <= 1'b0;
         done_reg   <= 1'b0;
         if (load) begin
            stored_reg <= preset;
            state_reg  <= IDLE;
            busy_reg   <= 1'b0;
            if (|bad_digit) begin
               err_reg <= 1'b1;
            end
         end else begin
            case (state_reg)
               IDLE, DONE: begin
                  if (start) begin
                     state_reg <= RUN;
                     busy_reg  <= 1'b1;
                  end
               end
               RUN: begin
                  if (terminal) begin
                     borrow_reg <= 1'b1;
                     if (WRAP == 0) begin
                        state_reg <= DONE;
                        done_reg  <= 1'b1;
                        busy_reg  <= 1'b0;
                     end
                  end
               end
               default: begin
                  state_reg <= IDLE;
                  busy_reg  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign borrow_out = borrow_reg;
   assign done       = done_reg;
   assign busy       = busy_reg;
   assign err        = err_reg;

endmodule
